inst_fetch_ram: RTL and testbench
=================================

# inst_fetch_ram

Parametrised, run-time loadable instruction memory with a registered fetch port for the pipelined CPU's IF stage. Holds `DEPTH` words of `INST_W` bits, each a 5-bit opcode plus operand. Words are programmed through a load port before execution. Fetches take one clock and support pipeline stall and flush. Out-of-range and never-written addresses return a HALT word, so runaway PCs stop the core.

## Interface
Parameters:
- `INST_W`, 9, instruction width: opcode in the upper 5 bits, operand in the rest.
- `ADDR_W`, 16, width of `pc` and `prog_addr`.
- `DEPTH`, 128, number of stored words. Legal addresses are 0..DEPTH-1.
- `HALT_WORD`, 9'h1A0, word returned for invalid fetches: opcode 5'b11010, operand 0.

Ports:
- `clk` in, 1: single clock. Everything is rising-edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `load_start` in, 1: enter LOAD state.
- `prog_we` in, 1: write strobe, honoured only in LOAD.
- `prog_addr` in, ADDR_W: write address.
- `prog_data` in, INST_W: write data.
- `load_done` in, 1: leave LOAD and enter RUN.
- `fetch_en` in, 1: request a fetch at `pc`.
- `stall` in, 1: hold the current fetch output.
- `flush` in, 1: squash the fetch output.
- `pc` in, ADDR_W: fetch address.
- `instruction` out, INST_W: registered fetched word.
- `inst_valid` out, 1: `instruction` is a live fetch.
- `busy` out, 1: high while in LOAD.
- `parity_err` out, 1: present only with `INST_PARITY_EN`.

## Operation
- Storage: word array `mem[DEPTH]` plus one written-flag per word, `wv[DEPTH]`.
  - `mem` is not reset.
  - `wv` is cleared by reset and on every transition into LOAD.
- FSM states: IDLE (reset state), LOAD, RUN.
  - IDLE → LOAD on `load_start`. `load_done` is ignored in IDLE.
  - LOAD → RUN on `load_done`. `load_start` is ignored in LOAD.
  - RUN → LOAD on `load_start`. This clears `wv` and aborts fetching.
- Write: in LOAD with `prog_we`, if `prog_addr < DEPTH` then `mem[prog_addr] <= prog_data` and `wv[prog_addr] <= 1`.
  - Writes to out-of-range addresses are dropped silently.
  - `prog_we` is ignored outside LOAD.
  - `prog_we` and `load_done` in the same cycle: the write completes and the state becomes RUN.
- Fetch in RUN, evaluated in priority order:
  1. `flush`: `instruction <= HALT_WORD`, `inst_valid <= 0`. Flush overrides `stall` and `fetch_en`.
  2. `stall`: `instruction` and `inst_valid` hold.
  3. `fetch_en`: `instruction <= (pc < DEPTH && wv[pc]) ? mem[pc] : HALT_WORD`, `inst_valid <= 1`.
  4. Otherwise: `inst_valid <= 0` and `instruction` holds.
- In IDLE and LOAD: `instruction <= HALT_WORD`, `inst_valid <= 0`.
- `busy` is 1 exactly when the state is LOAD.
- Write in the same cycle as a fetch: not possible, because writes occur only in LOAD and fetches only in RUN.

## Timing
- Reset values: state IDLE, `instruction` = HALT_WORD, `inst_valid` = 0, `busy` = 0, `parity_err` = 0, all `wv` = 0.
- Fetch latency is 1 cycle: `pc` sampled at edge N appears on `instruction` after edge N.
- A stall asserted in cycle N holds the output presented after edge N-1.
- Write-to-read: a word written in LOAD is fetchable in the first RUN cycle.
- State changes take effect at the edge that samples the request. `busy` rises one cycle after `load_start`.
- Reset asserted mid-load drops the load immediately: state IDLE, `wv` cleared, outputs forced to reset values.

## Configuration
- `INST_PARITY_EN` defined:
  - Each word stores an extra even-parity bit computed from `prog_data` at write time.
  - On every fetch that returns a stored word, `parity_err` is registered high in the same cycle as `inst_valid` if the recomputed parity mismatches. `instruction` is still delivered unchanged.
  - `parity_err` is 0 for HALT_WORD substitutions, for flushes, and in IDLE and LOAD.
  - `parity_err` holds during a stall.
- `INST_PARITY_EN` undefined: no parity storage and no `parity_err` port.

## Test plan
- Reset check: assert `rst_n` = 0, then release, then fetch with `pc` = 0 while in IDLE → `instruction` = 0x1A0, `inst_valid` = 0, `busy` = 0.
- Load and run:
  - Stimulus: `load_start`, then write 0x0C1 to address 1 and 0x0A0 to address 2, then `load_done`, then fetch `pc` = 1 and `pc` = 2 on consecutive cycles.
  - Required response: 0x0C1, then 0x0A0, each one cycle after its `pc`, with `inst_valid` = 1.
- Invalid fetch addresses: fetch `pc` = 3 (never written) and `pc` = 200 (out of range) → both return 0x1A0 with `inst_valid` = 1. A `prog_we` to address 200 during LOAD changes nothing.
- Stall and flush:
  - Fetch `pc` = 1, then hold `stall` for 3 cycles while `pc` changes → 0x0C1 holds.
  - Then assert `stall` and `flush` together → `inst_valid` = 0 and `instruction` = 0x1A0.
- Reload: in RUN, assert `load_start` → `busy` = 1 next cycle. Then `load_done` with no writes, then fetch `pc` = 1 → 0x1A0.
- With `INST_PARITY_EN`: force-corrupt the stored parity of address 1, then fetch `pc` = 1 → `parity_err` = 1 and `instruction` = 0x0C1.

Source files
------------

// File: rtl/inst_fetch_ram.sv
// ---------------------------------------------------------------------------
// inst_fetch_ram
//
// Purpose:
//   Run-time loadable instruction memory with a registered fetch port for the
//   IF stage of a pipelined core. Words are programmed through a load port
//   while the block is in LOAD. Fetches happen in RUN, take one clock, and
//   support stall and flush. Fetches from out-of-range or never-written
//   addresses return HALT_WORD, so a runaway PC stops the core.
//
// Optional feature (macro INST_PARITY_EN):
//   When defined, each stored word carries an even-parity bit. A fetch that
//   returns a stored word whose parity no longer matches raises parity_err
//   alongside inst_valid. When undefined, there is no parity storage and no
//   parity_err port.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   load_start   in   enter LOAD (from IDLE or RUN)
//   prog_we      in   write strobe, honoured only in LOAD
//   prog_addr    in   [ADDR_W] write address
//   prog_data    in   [INST_W] write data
//   load_done    in   leave LOAD and enter RUN
//   fetch_en     in   request a fetch at pc
//   stall        in   hold the current fetch output
//   flush        in   squash the fetch output
//   pc           in   [ADDR_W] fetch address
//   instruction  out  [INST_W] registered fetched word
//   inst_valid   out  instruction is a live fetch
//   busy         out  high while in LOAD
//   parity_err   out  stored-word parity mismatch (INST_PARITY_EN only)
//
// Handshake: there is no backpressure. instruction/inst_valid are valid one
// cycle after the edge that sampled fetch_en; stall freezes them in place.
// ---------------------------------------------------------------------------
module inst_fetch_ram #(
   parameter int                INST_W    = 9,
   parameter int                ADDR_W    = 16,
   parameter int                DEPTH     = 128,
   parameter logic [INST_W-1:0] HALT_WORD = 9'h1A0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [INST_W-1:0] prog_data,
   input  logic              load_done,
   input  logic              fetch_en,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc,
   output logic [INST_W-1:0] instruction,
   output logic              inst_valid,
   output logic              busy
`ifdef INST_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so the range compare cannot wrap for any ADDR_W.
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Storage. mem_q is deliberately not reset; wv_q tracks which words hold
   // real program data for the current load.
   logic [INST_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  wv_q;

   logic [INST_W-1:0] instr_q, instr_d;
   logic              valid_q, valid_d;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic             wr_in_range;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic             rd_in_range;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_hit;
   logic [INST_W-1:0] rd_word;
   logic             enter_load;

   assign wr_in_range = ({1'b0, prog_addr} < DEPTH_LIM);
   assign wr_idx      = prog_addr[IDX_W-1:0];
   assign wr_en       = (state_q == S_LOAD) && prog_we && wr_in_range;

   assign rd_in_range = ({1'b0, pc} < DEPTH_LIM);
   assign rd_idx      = pc[IDX_W-1:0];
   assign rd_word     = mem_q[rd_idx];
   assign rd_hit      = rd_in_range && wv_q[rd_idx];

   // wv is wiped on every entry into LOAD so a reload starts from nothing.
   assign enter_load  = (state_q != S_LOAD) && (state_d == S_LOAD);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (load_start) state_d = S_LOAD;
         S_LOAD:  if (load_done)  state_d = S_RUN;
         S_RUN:   if (load_start) state_d = S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Storage write
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wv_q <= '0;
      end else if (enter_load) begin
         wv_q <= '0;
      end else if (wr_en) begin
         wv_q[wr_idx] <= 1'b1;
      end
   end

`ifdef INST_PARITY_EN
   // Even parity: stored bit equals XOR of the data, so data plus bit has an
   // even number of ones.
   logic par_q [DEPTH];
   logic par_bad;
   logic perr_q, perr_d;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         par_q[wr_idx] <= ^prog_data;
      end
   end

   assign par_bad = (^rd_word) != par_q[rd_idx];
`endif

   // ------------------------------------------------------------------
   // Fetch output register
   // ------------------------------------------------------------------
   always_comb begin
      instr_d = instr_q;
      valid_d = valid_q;
`ifdef INST_PARITY_EN
      perr_d  = perr_q;
`endif
      // A load_start seen in RUN aborts fetching at the same edge that
      // moves the FSM into LOAD.
      if ((state_q != S_RUN) || load_start || flush) begin
         instr_d = HALT_WORD;
         valid_d = 1'b0;
`ifdef INST_PARITY_EN
         perr_d  = 1'b0;
`endif
      end else if (stall) begin
         // hold everything
      end else if (fetch_en) begin
         instr_d = rd_hit ? rd_word : HALT_WORD;
         valid_d = 1'b1;
`ifdef INST_PARITY_EN
         perr_d  = rd_hit && par_bad;
`endif
      end else begin
         valid_d = 1'b0;
`ifdef INST_PARITY_EN
         perr_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= HALT_WORD;
         valid_q <= 1'b0;
`ifdef INST_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         instr_q <= instr_d;
         valid_q <= valid_d;
`ifdef INST_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign instruction = instr_q;
   assign inst_valid  = valid_q;
   assign busy        = (state_q == S_LOAD);
`ifdef INST_PARITY_EN
   assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ram.sv
// Bench for inst_fetch_ram: directed stimulus, a behavioural reference model
// updated on every rising edge, a per-cycle compare process on the falling
// edge, and literal checks at the interesting points of the sequence.
module tb_inst_fetch_ram;
  localparam logic [8:0] HALT = 9'h1A0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        load_start = 0, prog_we = 0, load_done = 0;
  logic        fetch_en = 0, stall = 0, flush = 0;
  logic [15:0] prog_addr = '0, pc = '0;
  logic [8:0]  prog_data = '0;
  logic [8:0]  instruction;
  logic        inst_valid, busy;
`ifdef INST_PARITY_EN
  logic        parity_err;
`endif

  inst_fetch_ram dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .load_done(load_done),
    .fetch_en(fetch_en), .stall(stall), .flush(flush), .pc(pc),
    .instruction(instruction), .inst_valid(inst_valid), .busy(busy)
`ifdef INST_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: mode 0=idle 1=load 2=run
  int         m_mode;
  logic [8:0] m_mem [128];
  bit         m_wv  [128];
  bit         m_bad [128];
  logic [8:0] e_instr;
  logic       e_valid;
  logic       e_perr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = 0;
      e_instr = HALT;
      e_valid = 0;
      e_perr  = 0;
      foreach (m_wv[i]) m_wv[i] = 0;
    end else begin
      if (m_mode != 2 || load_start || flush) begin
        e_instr = HALT; e_valid = 0; e_perr = 0;
      end else if (stall) begin
        // outputs frozen
      end else if (fetch_en) begin
        if (pc < 128 && m_wv[pc]) begin
          e_instr = m_mem[pc]; e_perr = m_bad[pc];
        end else begin
          e_instr = HALT; e_perr = 0;
        end
        e_valid = 1;
      end else begin
        e_valid = 0; e_perr = 0;
      end
      if (m_mode == 1 && prog_we && prog_addr < 128) begin
        m_mem[prog_addr] = prog_data;
        m_wv[prog_addr]  = 1;
        m_bad[prog_addr] = 0;
      end
      if ((m_mode == 0 || m_mode == 2) && load_start) begin
        foreach (m_wv[i]) m_wv[i] = 0;
        m_mode = 1;
      end else if (m_mode == 1 && load_done) begin
        m_mode = 2;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (mon_en) begin
      check("cyc_instruction", 32'(instruction), 32'(e_instr));
      check("cyc_inst_valid", 32'(inst_valid), 32'(e_valid));
      check("cyc_busy", 32'(busy), 32'(m_mode == 1));
`ifdef INST_PARITY_EN
      check("cyc_parity_err", 32'(parity_err), 32'(e_perr));
`endif
    end
  end

  // driver helpers
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [15:0] a, input logic [8:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 0;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [8:0] exp_i, input logic exp_v);
    fetch_en = 1; pc = a;
    cyc();
    check("fetch_instr", 32'(instruction), 32'(exp_i));
    check("fetch_valid", 32'(inst_valid), 32'(exp_v));
  endtask

  initial begin
    foreach (m_bad[i]) m_bad[i] = 0;
    #1 rst_n = 0;
    mon_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // IDLE: fetch and load_done are both ignored
    fetch_en = 1; pc = 0; load_done = 1;
    cyc();
    check("idle_instr", 32'(instruction), 32'h1A0);
    check("idle_valid", 32'(inst_valid), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    fetch_en = 0; load_done = 0;

    // LOAD
    load_start = 1;
    cyc();
    check("load_busy", 32'(busy), 32'h1);
    load_start = 0;
    write_word(16'd1, 9'h0C1);
    write_word(16'd2, 9'h0A0);
    write_word(16'd200, 9'h055);       // dropped; must not alias to 72
    load_done = 1;                      // write and load_done together
    write_word(16'd5, 9'h123);
    load_done = 0;
    check("run_busy", 32'(busy), 32'h0);

    // RUN fetches
    fetch(16'd1, 9'h0C1, 1'b1);
    fetch(16'd2, 9'h0A0, 1'b1);
    fetch(16'd3, HALT, 1'b1);
    fetch(16'd200, HALT, 1'b1);
    fetch(16'd72, HALT, 1'b1);
    fetch(16'd5, 9'h123, 1'b1);
    fetch_en = 0;
    cyc();
    check("idle_fetch_valid", 32'(inst_valid), 32'h0);
    check("idle_fetch_hold", 32'(instruction), 32'h123);

    // prog_we outside LOAD is ignored
    prog_we = 1; prog_addr = 16'd3; prog_data = 9'h0FF;
    fetch(16'd3, HALT, 1'b1);
    prog_we = 0;
    fetch(16'd3, HALT, 1'b1);

    // stall holds the previous output while pc moves
    fetch(16'd1, 9'h0C1, 1'b1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      pc = (i == 0) ? 16'd2 : (i == 1) ? 16'd3 : 16'd5;
      cyc();
      check("stall_instr", 32'(instruction), 32'h0C1);
      check("stall_valid", 32'(inst_valid), 32'h1);
    end
    flush = 1;
    cyc();
    check("flush_instr", 32'(instruction), 32'h1A0);
    check("flush_valid", 32'(inst_valid), 32'h0);
    stall = 0; flush = 0;

`ifdef INST_PARITY_EN
    dut.par_q[1] = ~dut.par_q[1];
    m_bad[1] = 1;
    fetch(16'd1, 9'h0C1, 1'b1);
    check("perr_set", 32'(parity_err), 32'h1);
    fetch(16'd2, 9'h0A0, 1'b1);
    check("perr_clear", 32'(parity_err), 32'h0);
`endif

    // flush alone beats fetch_en
    flush = 1;
    fetch(16'd1, HALT, 1'b0);
    flush = 0;

    // reload aborts fetching and clears the written flags
    fetch(16'd2, 9'h0A0, 1'b1);
    load_start = 1;
    cyc();
    check("reload_busy", 32'(busy), 32'h1);
    check("reload_valid", 32'(inst_valid), 32'h0);
    check("reload_instr", 32'(instruction), 32'h1A0);
    load_start = 0; fetch_en = 0;
    cyc();
    load_done = 1;
    cyc();
    load_done = 0;
    check("reload_run_busy", 32'(busy), 32'h0);
    fetch(16'd1, HALT, 1'b1);
    fetch(16'd2, HALT, 1'b1);

    // reset in the middle of a load
    fetch_en = 0;
    load_start = 1;
    cyc();
    load_start = 0;
    write_word(16'd1, 9'h0C1);
    #2 rst_n = 0;
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_instr", 32'(instruction), 32'h1A0);
    @(negedge clk);
    rst_n = 1;
    load_done = 1;                      // ignored in IDLE
    cyc();
    load_done = 0;
    check("post_rst_busy", 32'(busy), 32'h0);
    fetch(16'd1, HALT, 1'b0);
    fetch_en = 0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
